state_dump_tx: RTL and testbench

- Serialises architectural state to the host after program end: register file, then data memory, as ASCII text.
- Sits between the core's state arrays and the UART transmitter; drives the transmitter's byte input through a valid/ready handshake.
- Owns the whole dump sequence, removing the ad-hoc dump logic from the top level.
- Reads state through dedicated read ports only; never probes hierarchically into the core.

---
 rtl/state_dump_tx.sv | 181 ++++++++++++++++++
 tb/tb_state_dump_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_tx.sv
// Post-run state dump: streams the register file and then data memory to the UART as
// ASCII '0'/'1' lines, each under its own text header, using a valid/ready byte handshake.
module state_dump_tx #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_WORDS      = 64,
  parameter int MEM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic                      tx_valid,
  output logic [7:0]                tx_byte,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int BitCntWidth = $clog2(DATA_WIDTH + 1);
  localparam logic [REG_ADDR_WIDTH-1:0] LastReg = REG_ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LastMem = MEM_ADDR_WIDTH'(MEM_WORDS - 1);
  localparam logic [BitCntWidth-1:0]    LastBit = BitCntWidth'(DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE, HDR_REGS, REG_FETCH, REG_BITS, REG_EOL,
    HDR_MEM, MEM_FETCH, MEM_BITS, MEM_EOL, DONE
  } state_t;

  state_t                   state, state_next;
  logic                     start_q;
  logic [2:0]               hdr_idx;
  logic [BitCntWidth-1:0]   bit_cnt;
  logic                     eol_lf;
  logic                     fetch_load;
  logic [DATA_WIDTH-1:0]    shreg;
  logic [REG_ADDR_WIDTH-1:0] reg_idx;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;

  function automatic logic [7:0] hdr_char(input logic mem_sel, input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    if (!mem_sel) begin
      case (idx)
        3'd0: c = 8'h52;
        3'd1: c = 8'h45;
        3'd2: c = 8'h47;
        3'd3: c = 8'h53;
        3'd4: c = 8'h3A;
        3'd5: c = 8'h0D;
        default: c = 8'h0A;
      endcase
    end else begin
      case (idx)
        3'd0: c = 8'h4D;
        3'd1: c = 8'h45;
        3'd2: c = 8'h4D;
        3'd3: c = 8'h3A;
        3'd4: c = 8'h0D;
        default: c = 8'h0A;
      endcase
    end
    return c;
  endfunction

  assign reg_rd_addr = reg_idx;
  assign mem_rd_addr = mem_idx;

  // Outputs decode purely from registered state, so tx_byte cannot move while a byte is stalled.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_q) state_next = HDR_REGS;
      end
      HDR_REGS: begin
        tx_valid = 1'b1;
        tx_byte  = hdr_char(1'b0, hdr_idx);
        if (tx_ready && hdr_idx == 3'd6) state_next = REG_FETCH;
      end
      REG_FETCH: if (fetch_load) state_next = REG_BITS;
      REG_BITS: begin
        tx_valid = 1'b1;
        tx_byte  = {7'h18, shreg[DATA_WIDTH-1]};
        if (tx_ready && bit_cnt == LastBit) state_next = REG_EOL;
      end
      REG_EOL: begin
        tx_valid = 1'b1;
        tx_byte  = eol_lf ? 8'h0A : 8'h0D;
        if (tx_ready && eol_lf) state_next = (reg_idx == LastReg) ? HDR_MEM : REG_FETCH;
      end
      HDR_MEM: begin
        tx_valid = 1'b1;
        tx_byte  = hdr_char(1'b1, hdr_idx);
        if (tx_ready && hdr_idx == 3'd5) state_next = MEM_FETCH;
      end
      MEM_FETCH: if (fetch_load) state_next = MEM_BITS;
      MEM_BITS: begin
        tx_valid = 1'b1;
        tx_byte  = {7'h18, shreg[DATA_WIDTH-1]};
        if (tx_ready && bit_cnt == LastBit) state_next = MEM_EOL;
      end
      MEM_EOL: begin
        tx_valid = 1'b1;
        tx_byte  = eol_lf ? 8'h0A : 8'h0D;
        if (tx_ready && eol_lf) state_next = (mem_idx == LastMem) ? DONE : MEM_FETCH;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // start is registered once; fetch states spend one cycle addressing and one loading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      hdr_idx    <= '0;
      bit_cnt    <= '0;
      eol_lf     <= 1'b0;
      fetch_load <= 1'b0;
      shreg      <= '0;
      reg_idx    <= '0;
      mem_idx    <= '0;
    end else begin
      state   <= state_next;
      start_q <= start;
      case (state)
        IDLE: begin
          hdr_idx    <= '0;
          bit_cnt    <= '0;
          eol_lf     <= 1'b0;
          fetch_load <= 1'b0;
          reg_idx    <= '0;
          mem_idx    <= '0;
        end
        HDR_REGS, HDR_MEM: if (tx_ready) hdr_idx <= hdr_idx + 3'd1;
        REG_FETCH, MEM_FETCH: begin
          fetch_load <= ~fetch_load;
          hdr_idx    <= '0;
          bit_cnt    <= '0;
          eol_lf     <= 1'b0;
          if (fetch_load) shreg <= (state == REG_FETCH) ? reg_rd_data : mem_rd_data;
        end
        REG_BITS, MEM_BITS: begin
          if (tx_ready) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        REG_EOL: begin
          if (tx_ready) begin
            eol_lf <= ~eol_lf;
            if (eol_lf && reg_idx != LastReg) reg_idx <= reg_idx + 1'b1;
          end
        end
        MEM_EOL: begin
          if (tx_ready) begin
            eol_lf <= ~eol_lf;
            if (eol_lf && mem_idx != LastMem) mem_idx <= mem_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dump_tx.sv
// Bench for state_dump_tx: captures accepted bytes, compares them with a reference stream
// and a table of hand-computed positions, and exercises reset, backpressure and re-arm.
module tb_state_dump_tx;

  localparam int DW = 32, NR = 32, RAW = 5, MW = 64, MAW = 6;
  localparam int TOTAL = 3277;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic [RAW-1:0] reg_rd_addr;
  logic [MAW-1:0] mem_rd_addr;
  logic [DW-1:0]  reg_rd_data = '0, mem_rd_data = '0;
  logic           tx_valid, busy, done;
  logic [7:0]     tx_byte;

  state_dump_tx #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_WIDTH(RAW),
                  .MEM_WORDS(MW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] reg_file [NR];
  logic [DW-1:0] dmem [MW];

  // Synchronous read ports with one cycle of latency.
  always @(posedge clk) begin
    reg_rd_data <= reg_file[reg_rd_addr];
    mem_rd_data <= dmem[mem_rd_addr];
  end

  typedef struct {
    string      name;
    int         pos;
    logic [7:0] expected;
  } spot_t;

  spot_t      spots [28];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         vectors = 0, miscompares = 0;
  int         stall_errs;
  logic       prev_stall;
  logic [7:0] prev_byte;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: pick tx_ready at the negedge, watch stall stability, log the byte that will transfer.
  task automatic applyStimulus(input int pct);
    @(negedge clk);
    if (prev_stall && (!tx_valid || tx_byte !== prev_byte)) stall_errs++;
    tx_ready   = ($urandom_range(99) < pct);
    prev_stall = tx_valid && !tx_ready;
    prev_byte  = tx_byte;
    if (tx_valid && tx_ready) got_q.push_back(tx_byte);
  endtask

  task automatic buildExpected();
    string hr, hm;
    hr = "REGS:";
    hm = "MEM:";
    exp_q.delete();
    for (int i = 0; i < hr.len(); i++) exp_q.push_back(hr[i]);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    for (int r = 0; r < NR; r++) begin
      for (int b = DW - 1; b >= 0; b--) exp_q.push_back(reg_file[r][b] ? 8'h31 : 8'h30);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
    for (int i = 0; i < hm.len(); i++) exp_q.push_back(hm[i]);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    for (int w = 0; w < MW; w++) begin
      for (int b = DW - 1; b >= 0; b--) exp_q.push_back(dmem[w][b] ? 8'h31 : 8'h30);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endtask

  function automatic int streamDiffs();
    int n, d;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // Runs a dump from a fresh start edge; abort_at >= 0 pulls reset while that byte index is offered.
  task automatic runDump(input int pct, input int abort_at, output int latency, output bit timed_out);
    got_q.delete();
    prev_stall = 1'b0;
    latency    = -1;
    timed_out  = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40000; c++) begin
      applyStimulus(pct);
      if (latency < 0 && tx_valid) latency = c;
      if (abort_at >= 0 && got_q.size() == abort_at && tx_valid) begin
        #1 rst = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("abort tx_valid", {31'b0, tx_valid}, 32'd0);
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        timed_out = 1'b0;
        return;
      end
      if (done) begin
        timed_out = 1'b0;
        return;
      end
    end
  endtask

  task automatic rearm();
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFullDump(input string tag, input int latency, input bit timed_out);
    checkOutput({tag, " timeout"}, {31'b0, timed_out}, 32'd0);
    checkOutput({tag, " latency"}, latency, 32'd2);
    checkOutput({tag, " length"}, got_q.size(), TOTAL);
    checkOutput({tag, " stream diffs"}, streamDiffs(), 32'd0);
    checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, " busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int  lat, bad, held;
    bit  to;

    spots[0]  = '{"hdr R", 0, 8'h52};      spots[1]  = '{"hdr colon", 4, 8'h3A};
    spots[2]  = '{"hdr CR", 5, 8'h0D};     spots[3]  = '{"hdr LF", 6, 8'h0A};
    spots[4]  = '{"r0 msb", 7, 8'h30};     spots[5]  = '{"r0 lsb", 38, 8'h30};
    spots[6]  = '{"r0 CR", 39, 8'h0D};     spots[7]  = '{"r0 LF", 40, 8'h0A};
    spots[8]  = '{"r5 msb", 177, 8'h30};   spots[9]  = '{"r5 b3", 205, 8'h30};
    spots[10] = '{"r5 b2", 206, 8'h31};    spots[11] = '{"r5 b1", 207, 8'h30};
    spots[12] = '{"r5 b0", 208, 8'h31};    spots[13] = '{"r5 CR", 209, 8'h0D};
    spots[14] = '{"r31 b5", 1087, 8'h30};  spots[15] = '{"r31 b4", 1088, 8'h31};
    spots[16] = '{"r31 b0", 1092, 8'h31};  spots[17] = '{"r31 LF", 1094, 8'h0A};
    spots[18] = '{"mhdr M", 1095, 8'h4D};  spots[19] = '{"mhdr E", 1096, 8'h45};
    spots[20] = '{"mhdr colon", 1098, 8'h3A}; spots[21] = '{"mhdr LF", 1100, 8'h0A};
    spots[22] = '{"m0 msb", 1101, 8'h31};  spots[23] = '{"m0 b30", 1102, 8'h30};
    spots[24] = '{"m63 b6", 3268, 8'h30};  spots[25] = '{"m63 b5", 3269, 8'h31};
    spots[26] = '{"m63 b0", 3274, 8'h31};  spots[27] = '{"last LF", 3276, 8'h0A};

    for (int k = 0; k < NR; k++) reg_file[k] = DW'(k);
    for (int w = 0; w < MW; w++) dmem[w] = 32'hA5A5_0000 + DW'(w);
    buildExpected();
    stall_errs = 0;
    prev_stall = 1'b0;

    // Idle after reset: nothing moves for 100 cycles.
    repeat (3) @(negedge clk);
    checkOutput("reset tx_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("reset outputs", {tx_byte, 3'b0, reg_rd_addr, 2'b0, mem_rd_addr, 6'b0, busy, done}, 32'd0);
    rst = 1'b1;
    bad = 0;
    got_q.delete();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(100);
      if (tx_valid || busy || done || tx_byte != 8'h00 || reg_rd_addr != '0 || mem_rd_addr != '0) bad++;
    end
    checkOutput("idle bad cycles", bad, 32'd0);
    checkOutput("idle bytes", got_q.size(), 32'd0);

    $display("[TB] full dump, tx_ready always high");
    runDump(100, -1, lat, to);
    checkFullDump("full", lat, to);
    for (int i = 0; i < $size(spots); i++)
      checkOutput(spots[i].name, (spots[i].pos < got_q.size()) ? {24'b0, got_q[spots[i].pos]} : 32'hFFFF_FFFF,
                  {24'b0, spots[i].expected});

    $display("[TB] re-arm: start held after done");
    held = got_q.size();
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(100);
      if (tx_valid || !done) bad++;
    end
    checkOutput("held start extra bytes", got_q.size() - held, 32'd0);
    checkOutput("held start bad cycles", bad, 32'd0);
    rearm();
    checkOutput("rearm done cleared", {31'b0, done}, 32'd0);
    checkOutput("rearm busy", {31'b0, busy}, 32'd0);
    runDump(100, -1, lat, to);
    checkFullDump("second", lat, to);

    $display("[TB] backpressure, tx_ready about 30 percent");
    rearm();
    stall_errs = 0;
    runDump(30, -1, lat, to);
    checkOutput("bp timeout", {31'b0, to}, 32'd0);
    checkOutput("bp length", got_q.size(), TOTAL);
    checkOutput("bp stream diffs", streamDiffs(), 32'd0);
    checkOutput("bp stall changes", stall_errs, 32'd0);

    $display("[TB] reset during reg 10 bit 7");
    rearm();
    runDump(100, 7 + 10 * 34 + 7, lat, to);
    checkOutput("abort reached", {31'b0, to}, 32'd0);
    @(negedge clk);
    checkOutput("abort held tx_valid", {31'b0, tx_valid}, 32'd0);
    rst = 1'b1;
    runDump(100, -1, lat, to);
    checkOutput("restart first byte", (got_q.size() > 0) ? {24'b0, got_q[0]} : 32'hFFFF_FFFF, 32'h52);
    checkFullDump("restart", lat, to);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
